// File: rtl/mesh_test_pkg.sv
// Shared types and constants for the mesh traffic test controller and its
// pattern lookup.
package mesh_test_pkg;

    localparam int NUM_PE = 8;
    localparam int CNT_W  = 3;
    localparam int RATE_W = 4;
    localparam int DST_W  = 24;
    localparam int MODE_W = 4;
    localparam int IDX_W  = $clog2(NUM_PE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        PAT_COMPLEMENT = 3'd0,
        PAT_REVERSE    = 3'd1,
        PAT_ROTATION   = 3'd2,
        PAT_SHUFFLE    = 3'd3,
        PAT_TORNADO    = 3'd4,
        PAT_NEIGHBOR   = 3'd5,
        PAT_HOTSPOT    = 3'd6,
        PAT_TURN       = 3'd7
    } pattern_t;

    typedef logic [NUM_PE-1:0][CNT_W-1:0] cnt_vec_t;

    typedef struct packed {
        logic [NUM_PE-1:0]             dbg;
        cnt_vec_t                      send;
        cnt_vec_t                      recv;
        logic [NUM_PE-1:0][RATE_W-1:0] rate;
        logic [NUM_PE-1:0][DST_W-1:0]  dst;
        logic [NUM_PE-1:0][MODE_W-1:0] mode;
    } pe_cfg_t;

    // A PE only takes part in completion if it has something to send/receive.
    function automatic logic [NUM_PE-1:0] nonzero_mask(input cnt_vec_t cnt);
        logic [NUM_PE-1:0] m;
        for (int i = 0; i < NUM_PE; i++) m[i] = |cnt[i];
        return m;
    endfunction

endpackage

// File: rtl/mesh_pattern_rom.sv
// Combinational lookup from a traffic pattern code to the full per-PE
// configuration bundle.
module mesh_pattern_rom
    import mesh_test_pkg::*;
(
    input  logic [2:0] pattern_sel,
    output pe_cfg_t    cfg
);

    logic [NUM_PE-1:0][IDX_W-1:0] dst_idx;

    // Destination PE per source, listed PE7 down to PE0.
    always_comb begin
        dst_idx = '0;
        case (pattern_t'(pattern_sel))
            PAT_COMPLEMENT: dst_idx = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
            PAT_REVERSE:    dst_idx = {3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0};
            PAT_ROTATION:   dst_idx = {3'd7, 3'd3, 3'd6, 3'd2, 3'd5, 3'd1, 3'd4, 3'd0};
            PAT_SHUFFLE:    dst_idx = {3'd7, 3'd5, 3'd3, 3'd1, 3'd6, 3'd4, 3'd2, 3'd0};
            PAT_TORNADO:    dst_idx = {3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
            PAT_NEIGHBOR:   dst_idx = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
            default:        dst_idx = '0;
        endcase
    end

    always_comb begin
        cfg     = '0;
        cfg.dbg = '1;
        for (int i = 0; i < NUM_PE; i++) begin
            cfg.dst[i]  = DST_W'(dst_idx[i]);
            cfg.rate[i] = '0;
            case (pattern_t'(pattern_sel))
                // Everyone fires one packet at PE0, which expects all seven.
                PAT_HOTSPOT: begin
                    cfg.send[i] = (i == 0) ? 3'd0 : 3'd1;
                    cfg.recv[i] = (i == 0) ? 3'd7 : 3'd0;
                    cfg.mode[i] = 4'd1;
                end
                PAT_TURN: begin
                    cfg.send[i] = 3'd7;
                    cfg.recv[i] = 3'd7;
                    cfg.mode[i] = 4'd0;
                end
                default: begin
                    cfg.send[i] = 3'd1;
                    cfg.recv[i] = 3'd1;
                    cfg.mode[i] = 4'd1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mesh_test_ctrl.sv
// Sequences one mesh traffic test: load config, flush PEs, settle, run until
// all participating PEs report completion or the run budget expires.
module mesh_test_ctrl
    import mesh_test_pkg::*;
#(
    parameter int FLUSH_CYCLES   = 4,
    parameter int SETTLE_CYCLES  = 50,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [2:0]                pattern_sel,
    output logic [NUM_PE-1:0]         pe_enable,
    output logic [NUM_PE-1:0]         pe_flush_wire,
    output logic [NUM_PE-1:0]         pe_dbg_mode_wire,
    output logic [NUM_PE*CNT_W-1:0]   pe_send_num_wire,
    output logic [NUM_PE*CNT_W-1:0]   pe_receive_num_wire,
    output logic [NUM_PE*RATE_W-1:0]  pe_rate_wire,
    output logic [NUM_PE*DST_W-1:0]   pe_dst_seq_wire,
    output logic [NUM_PE*MODE_W-1:0]  pe_mode_wire,
    input  logic [NUM_PE-1:0]         pe_task_send_finish_flag,
    input  logic [NUM_PE-1:0]         pe_task_receive_finish_flag,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [31:0]               cycle_count
);

    localparam logic [31:0] FLUSH_LAST  = 32'(FLUSH_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    state_t            state;
    logic [2:0]        pattern_q;
    pe_cfg_t           rom_cfg;
    pe_cfg_t           cfg_q;
    logic [31:0]       phase_cnt;
    logic [31:0]       cycle_next;
    logic [NUM_PE-1:0] send_mask;
    logic [NUM_PE-1:0] recv_mask;
    logic              run_complete;
    logic              run_expired;

    mesh_pattern_rom u_rom (
        .pattern_sel (pattern_q),
        .cfg         (rom_cfg)
    );

    assign send_mask = nonzero_mask(cfg_q.send);
    assign recv_mask = nonzero_mask(cfg_q.recv);

    assign run_complete = ((pe_task_send_finish_flag & send_mask) == send_mask) &&
                          ((pe_task_receive_finish_flag & recv_mask) == recv_mask);

    // cycle_next already includes the current RUN cycle.
    assign cycle_next  = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
    assign run_expired = (cycle_next >= TIMEOUT_LIM);

    assign busy                = (state != ST_IDLE);
    assign pe_dbg_mode_wire    = cfg_q.dbg;
    assign pe_send_num_wire    = cfg_q.send;
    assign pe_receive_num_wire = cfg_q.recv;
    assign pe_rate_wire        = cfg_q.rate;
    assign pe_dst_seq_wire     = cfg_q.dst;
    assign pe_mode_wire        = cfg_q.mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pattern_q     <= '0;
            cfg_q         <= '0;
            phase_cnt     <= '0;
            pe_enable     <= '0;
            pe_flush_wire <= '1;
            done          <= 1'b0;
            timeout       <= 1'b0;
            cycle_count   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Hold PEs in flush while idle after an abort; counters keep
                // their values for post-mortem.
                state         <= ST_IDLE;
                pe_enable     <= '0;
                pe_flush_wire <= '1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            pattern_q   <= pattern_sel;
                            timeout     <= 1'b0;
                            cycle_count <= '0;
                            state       <= ST_CONFIG;
                        end
                    end
                    ST_CONFIG: begin
                        cfg_q         <= rom_cfg;
                        phase_cnt     <= '0;
                        pe_flush_wire <= '1;
                        state         <= ST_FLUSH;
                    end
                    ST_FLUSH: begin
                        if (phase_cnt == FLUSH_LAST) begin
                            phase_cnt     <= '0;
                            pe_flush_wire <= '0;
                            state         <= ST_SETTLE;
                        end else begin
                            phase_cnt <= phase_cnt + 32'd1;
                        end
                    end
                    ST_SETTLE: begin
                        if (phase_cnt == SETTLE_LAST) begin
                            phase_cnt <= '0;
                            pe_enable <= '1;
                            state     <= ST_RUN;
                        end else begin
                            phase_cnt <= phase_cnt + 32'd1;
                        end
                    end
                    ST_RUN: begin
                        cycle_count <= cycle_next;
                        // Completion beats an expiry landing on the same cycle.
                        if (run_complete || run_expired) begin
                            timeout   <= !run_complete;
                            done      <= 1'b1;
                            pe_enable <= '0;
                            state     <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        pe_enable <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mesh_test_ctrl.sv
// Directed bench for mesh_test_ctrl with a timeline-based reference model
// checked every cycle plus hand-computed spot checks.
module tb_mesh_test_ctrl;

    localparam int F   = 4;
    localparam int S   = 50;
    localparam int TMO = 100;

    logic         clk = 1'b0;
    logic         rst, start, abort;
    logic [2:0]   pattern_sel;
    logic [7:0]   send_flags, recv_flags;
    logic [7:0]   pe_enable, pe_flush_wire, pe_dbg_mode_wire;
    logic [23:0]  pe_send_num_wire, pe_receive_num_wire;
    logic [31:0]  pe_rate_wire, pe_mode_wire;
    logic [191:0] pe_dst_seq_wire;
    logic         busy, done, timeout;
    logic [31:0]  cycle_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;

    mesh_test_ctrl #(
        .FLUSH_CYCLES   (F),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .start                       (start),
        .abort                       (abort),
        .pattern_sel                 (pattern_sel),
        .pe_enable                   (pe_enable),
        .pe_flush_wire               (pe_flush_wire),
        .pe_dbg_mode_wire            (pe_dbg_mode_wire),
        .pe_send_num_wire            (pe_send_num_wire),
        .pe_receive_num_wire         (pe_receive_num_wire),
        .pe_rate_wire                (pe_rate_wire),
        .pe_dst_seq_wire             (pe_dst_seq_wire),
        .pe_mode_wire                (pe_mode_wire),
        .pe_task_send_finish_flag    (send_flags),
        .pe_task_receive_finish_flag (recv_flags),
        .busy                        (busy),
        .done                        (done),
        .timeout                     (timeout),
        .cycle_count                 (cycle_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pattern table expressed as the traffic formulas themselves.
    function automatic int dst_of(input int p, input int i);
        case (p)
            0: return 7 - i;
            1: return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
            2: return ((i >> 1) & 3) | ((i & 1) << 2);
            3: return ((i << 1) & 6) | ((i >> 2) & 1);
            4: return (i + 3) % 8;
            5: return (i + 1) % 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [23:0] exp_send(input int p);
        logic [23:0] v = '0;
        for (int i = 0; i < 8; i++)
            v[i*3 +: 3] = (p == 7) ? 3'd7 : (p == 6 && i == 0) ? 3'd0 : 3'd1;
        return v;
    endfunction

    function automatic logic [23:0] exp_recv(input int p);
        logic [23:0] v = '0;
        for (int i = 0; i < 8; i++)
            v[i*3 +: 3] = (p == 7) ? 3'd7 : (p == 6) ? ((i == 0) ? 3'd7 : 3'd0) : 3'd1;
        return v;
    endfunction

    function automatic logic [31:0] exp_mode(input int p);
        logic [31:0] v = '0;
        for (int i = 0; i < 8; i++) v[i*4 +: 4] = (p == 7) ? 4'd0 : 4'd1;
        return v;
    endfunction

    function automatic logic [191:0] exp_dst(input int p);
        logic [191:0] v = '0;
        for (int i = 0; i < 8; i++) v[i*24 +: 24] = 24'(dst_of(p, i));
        return v;
    endfunction

    function automatic logic completes(input int p, input logic [7:0] sf, input logic [7:0] rf);
        logic [23:0] sn = exp_send(p);
        logic [23:0] rn = exp_recv(p);
        logic ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (sn[i*3 +: 3] != 0 && !sf[i]) ok = 1'b0;
            if (rn[i*3 +: 3] != 0 && !rf[i]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Model: m_t = cycles since the CONFIG cycle (-1 when idle); the test ends
    // on cycle m_done_at. Phases are fixed offsets from CONFIG.
    int          m_t = -1;
    int          m_done_at = -1;
    int          m_pat = 0;
    int          m_cfg_pat = 0;
    logic        m_valid = 1'b0;
    logic        m_cfg_valid = 1'b0;
    logic        m_to = 1'b0;
    logic [31:0] m_cc = '0;
    logic [7:0]  m_flush_idle = 8'hFF;

    always @(posedge clk) begin
        if (rst) begin
            m_valid      <= 1'b1;
            m_t          <= -1;
            m_done_at    <= -1;
            m_cfg_valid  <= 1'b0;
            m_to         <= 1'b0;
            m_cc         <= '0;
            m_flush_idle <= 8'hFF;
        end else if (abort) begin
            m_t          <= -1;
            m_flush_idle <= 8'hFF;
        end else if (m_t < 0) begin
            if (start) begin
                m_t       <= 0;
                m_done_at <= -1;
                m_pat     <= int'(pattern_sel);
                m_cc      <= '0;
                m_to      <= 1'b0;
            end
        end else if (m_t == m_done_at) begin
            m_t          <= -1;
            m_flush_idle <= 8'h00;
        end else begin
            if (m_t == 0) begin
                m_cfg_pat   <= m_pat;
                m_cfg_valid <= 1'b1;
            end
            if (m_t > F + S) begin
                m_cc <= sat_inc(m_cc);
                if (completes(m_cfg_pat, send_flags, recv_flags)) begin
                    m_done_at <= m_t + 1;
                    m_to      <= 1'b0;
                end else if (sat_inc(m_cc) >= TMO) begin
                    m_done_at <= m_t + 1;
                    m_to      <= 1'b1;
                end
            end
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", busy, m_t >= 0);
            chk("enable", pe_enable, (m_t > F + S && m_t != m_done_at) ? 8'hFF : 8'h00);
            chk("flush", pe_flush_wire,
                (m_t >= 1 && m_t <= F) ? 8'hFF : (m_t > F) ? 8'h00 : m_flush_idle);
            chk("done", done, m_t >= 0 && m_t == m_done_at);
            chk("timeout", timeout, m_to);
            chk("cycle_count", cycle_count, m_cc);
            chk("send_num", pe_send_num_wire, m_cfg_valid ? exp_send(m_cfg_pat) : 24'h0);
            chk("recv_num", pe_receive_num_wire, m_cfg_valid ? exp_recv(m_cfg_pat) : 24'h0);
            chk("mode", pe_mode_wire, m_cfg_valid ? exp_mode(m_cfg_pat) : 32'h0);
            chk("dst_seq", pe_dst_seq_wire, m_cfg_valid ? exp_dst(m_cfg_pat) : 192'h0);
            chk("rate", pe_rate_wire, 32'h0);
            if (!m_cfg_valid || m_cfg_pat < 6)
                chk("dbg_mode", pe_dbg_mode_wire, m_cfg_valid ? 8'hFF : 8'h00);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input int p);
        pattern_sel = 3'(p);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_en(output int at);
        int n = 0;
        at = -1;
        while (pe_enable !== 8'hFF && n < 200) begin
            tick(1);
            n++;
        end
        tests++;
        if (pe_enable !== 8'hFF) begin
            fails++;
            $display("FAIL wait_enable: enable=%0h after %0d cycles, expected FF", pe_enable, n);
        end else begin
            at = cyc;
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL wait_done: no done within %0d cycles", limit);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, r, d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; pattern_sel = '0;
        send_flags = '0; recv_flags = '0;
        tick(3);
        chk("rst_flush", pe_flush_wire, 8'hFF);
        chk("rst_enable", pe_enable, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        chk("rst_dst", pe_dst_seq_wire, 192'h0);
        rst = 1'b0;
        tick(2);

        // Pattern 0: flags rise 10 cycles into RUN.
        launch(0);
        c = cyc;
        wait_en(r);
        chk("enable_latency", r - c, 55);
        tick(10);
        send_flags = 8'hFF; recv_flags = 8'hFF;
        d0 = done_cnt;
        wait_done(50);
        chk("p0_cycle_count", cycle_count, 32'd11);
        chk("p0_timeout", timeout, 1'b0);
        tick(3);
        chk("p0_done_once", done_cnt - d0, 1);
        send_flags = '0; recv_flags = '0;

        // Hotspot: PE0 send flag irrelevant.
        launch(6);
        wait_en(r);
        send_flags = 8'hFE; recv_flags = 8'h01;
        wait_done(50);
        chk("p6_cycle_count", cycle_count, 32'd1);
        chk("p6_timeout", timeout, 1'b0);
        chk("p6_send_num", pe_send_num_wire, 24'o11111110);
        chk("p6_recv_num", pe_receive_num_wire, 24'd7);
        tick(2);
        send_flags = '0; recv_flags = '0;

        // Turn with one receive flag stuck low: runs out the budget.
        launch(7);
        wait_en(r);
        send_flags = 8'hFF; recv_flags = 8'hFE;
        wait_done(150);
        chk("p7_cycle_count", cycle_count, 32'd100);
        chk("p7_timeout", timeout, 1'b1);
        chk("p7_send_num", pe_send_num_wire, 24'o77777777);
        chk("p7_mode", pe_mode_wire, 32'h0);
        tick(2);
        send_flags = '0; recv_flags = '0;

        // Abort during RUN.
        launch(1);
        wait_en(r);
        chk("p1_dst", pe_dst_seq_wire, {24'd7, 24'd3, 24'd5, 24'd1, 24'd6, 24'd2, 24'd4, 24'd0});
        tick(5);
        abort = 1'b1;
        d0 = done_cnt;
        tick(1);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_enable", pe_enable, 8'h00);
        chk("abort_flush", pe_flush_wire, 8'hFF);
        chk("abort_cycle_count", cycle_count, 32'd5);
        tick(3);
        chk("abort_no_done", done_cnt - d0, 0);

        // Following test runs normally; a start during RUN is ignored.
        launch(2);
        wait_en(r);
        tick(1);
        pattern_sel = 3'd7;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("start_in_run_enable", pe_enable, 8'hFF);
        tick(1);
        send_flags = 8'hFF; recv_flags = 8'hFF;
        wait_done(50);
        chk("p2_cycle_count", cycle_count, 32'd4);
        chk("p2_mode", pe_mode_wire, 32'h11111111);
        tick(2);
        send_flags = '0; recv_flags = '0;

        // Completion on the very cycle the budget expires.
        launch(3);
        wait_en(r);
        tick(99);
        send_flags = 8'hFF; recv_flags = 8'hFF;
        wait_done(50);
        chk("tie_cycle_count", cycle_count, 32'd100);
        chk("tie_timeout", timeout, 1'b0);
        tick(2);
        send_flags = '0; recv_flags = '0;

        // Reset during SETTLE.
        launch(4);
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("srst_busy", busy, 1'b0);
        chk("srst_enable", pe_enable, 8'h00);
        chk("srst_flush", pe_flush_wire, 8'hFF);
        chk("srst_send_num", pe_send_num_wire, 24'h0);
        chk("srst_dbg", pe_dbg_mode_wire, 8'h00);
        tick(2);

        // Neighbor completes on its first RUN cycle.
        launch(5);
        wait_en(r);
        send_flags = 8'hFF; recv_flags = 8'hFF;
        wait_done(50);
        chk("p5_cycle_count", cycle_count, 32'd1);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
